// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow / pixel-composition slice.
package game_pkg;

  // Game-flow states; the encoding is visible on the state output.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    WIN       = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam int LIVES_W = 3;

  // 1-bit-per-channel colours, packed as {R, G, B}.
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLACK = 3'b000;

endpackage

// File: rtl/pixel_compositor.sv
// Two-stage colour datapath: stage 1 registers the pixel masks together with the
// game context, stage 2 resolves the colour priority and registers VGA_*.
module pixel_compositor
  import game_pkg::*;
#(
  parameter int NUM_LEVELS = 4,
  parameter int LVL_W      = 2,
  parameter int NUM_BLOCKS = 16,
  parameter int COLOR_W    = 8,
  parameter logic [NUM_LEVELS*NUM_BLOCKS-1:0] R_MASK = '0,
  parameter logic [NUM_LEVELS*NUM_BLOCKS-1:0] G_MASK = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  state_t                state,
  input  logic [LVL_W-1:0]      level,
  input  logic                  blink,
  input  logic                  screen_area,
  input  logic                  player,
  input  logic                  border,
  input  logic                  end_zone,
  input  logic [NUM_BLOCKS-1:0] blocks,
  input  logic                  banner_text,
  input  logic                  level_text,
  output logic [COLOR_W-1:0]    VGA_R,
  output logic [COLOR_W-1:0]    VGA_G,
  output logic [COLOR_W-1:0]    VGA_B
);

  state_t                s1_state;
  logic [LVL_W-1:0]      s1_level;
  logic                  s1_blink;
  logic                  s1_sa;
  logic                  s1_player;
  logic                  s1_border;
  logic                  s1_end;
  logic [NUM_BLOCKS-1:0] s1_blocks;
  logic                  s1_banner;
  logic                  s1_ltext;

  logic [NUM_BLOCKS-1:0] r_mask;
  logic [NUM_BLOCKS-1:0] g_mask;
  logic                  blk_r;
  logic                  blk_g;
  logic                  blk_b;
  logic [2:0]            rgb;

  // Stage 1: capture pixel masks and the game context they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_state  <= IDLE;
      s1_level  <= '0;
      s1_blink  <= 1'b0;
      s1_sa     <= 1'b0;
      s1_player <= 1'b0;
      s1_border <= 1'b0;
      s1_end    <= 1'b0;
      s1_blocks <= '0;
      s1_banner <= 1'b0;
      s1_ltext  <= 1'b0;
    end else begin
      s1_state  <= state;
      s1_level  <= level;
      s1_blink  <= blink;
      s1_sa     <= screen_area;
      s1_player <= player;
      s1_border <= border;
      s1_end    <= end_zone;
      s1_blocks <= blocks;
      s1_banner <= banner_text;
      s1_ltext  <= level_text;
    end
  end

  // Select the palette slices belonging to the registered level.
  always_comb begin
    r_mask = '0;
    g_mask = '0;
    for (int l = 0; l < NUM_LEVELS; l++) begin
      if (s1_level == LVL_W'(l)) begin
        r_mask = R_MASK[l*NUM_BLOCKS +: NUM_BLOCKS];
        g_mask = G_MASK[l*NUM_BLOCKS +: NUM_BLOCKS];
      end
    end
  end

  assign blk_r = |(s1_blocks & r_mask);
  assign blk_g = |(s1_blocks & g_mask);
  assign blk_b = |s1_blocks;

  // Resolve colour priority for the registered pixel.
  always_comb begin
    rgb = BLACK;
    if (s1_sa) begin
      case (s1_state)
        WIN:       rgb = {1'b0, ~s1_banner, 1'b0};
        GAME_OVER: rgb = {~s1_banner, 2'b00};
        IDLE, PLAY, DYING: begin
          if (s1_border && !s1_ltext) rgb = WHITE;
          else if (s1_player)         rgb = s1_blink ? BLACK : RED;
          else if (s1_end)            rgb = GREEN;
          else                        rgb = {blk_r, blk_g, blk_b};
        end
        default:   rgb = BLACK;
      endcase
    end
  end

  // Stage 2: register the colour, each channel bit widened to COLOR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else begin
      VGA_R <= {COLOR_W{rgb[2]}};
      VGA_G <= {COLOR_W{rgb[1]}};
      VGA_B <= {COLOR_W{rgb[0]}};
    end
  end

endmodule

// File: rtl/game_state_compositor.sv
// Game-flow FSM (title, play, death/respawn, win/advance, game over, level timer)
// plus the colour pipeline that drives the VGA pins.
module game_state_compositor
  import game_pkg::*;
#(
  parameter int NUM_LEVELS    = 4,
  parameter int LVL_W         = 2,
  parameter int NUM_BLOCKS    = 16,
  parameter int COLOR_W       = 8,
  parameter int LIVES         = 3,
  parameter int BANNER_FRAMES = 120,
  parameter int LEVEL_FRAMES  = 3600,
  parameter int AUTO_ADVANCE  = 1,
  parameter logic [NUM_LEVELS*NUM_BLOCKS-1:0] R_MASK = '0,
  parameter logic [NUM_LEVELS*NUM_BLOCKS-1:0] G_MASK = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  update,
  input  logic                  start,
  input  logic [LVL_W-1:0]      level_sel,
  input  logic                  hit,
  input  logic                  goal,
  input  logic                  screen_area,
  input  logic                  player,
  input  logic                  border,
  input  logic                  end_zone,
  input  logic [NUM_BLOCKS-1:0] blocks,
  input  logic                  banner_text,
  input  logic                  level_text,
  output logic                  respawn,
  output logic [LVL_W-1:0]      level,
  output logic [LIVES_W-1:0]    lives,
  output logic [2:0]            state,
  output logic [COLOR_W-1:0]    VGA_R,
  output logic [COLOR_W-1:0]    VGA_G,
  output logic [COLOR_W-1:0]    VGA_B
);

  // Banner counter keeps at least 4 bits so bit 3 can drive the death blink.
  localparam int TMR_W     = (LEVEL_FRAMES > 0) ? $clog2(LEVEL_FRAMES + 1) : 1;
  localparam int BAN_CLOG  = $clog2(BANNER_FRAMES + 1);
  localparam int BAN_W     = (BAN_CLOG > 4) ? BAN_CLOG : 4;
  localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'(LEVEL_FRAMES);
  localparam logic [BAN_W-1:0]   BAN_LAST   = BAN_W'(BANNER_FRAMES - 1);
  localparam logic [BAN_W-1:0]   BAN_DONE   = BAN_W'(BANNER_FRAMES);
  localparam logic [LVL_W-1:0]   LVL_MAX    = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  state_t           st;
  logic [TMR_W-1:0] timer;
  logic [BAN_W-1:0] banner;
  logic             start_q;
  logic             start_rise;
  logic             timer_expire;
  logic             blink;

  assign start_rise   = start & ~start_q;
  assign timer_expire = (LEVEL_FRAMES != 0) && update && (timer == TMR_W'(1));
  assign blink        = (st == DYING) && banner[3];
  assign state        = st;

  // Game-flow FSM with lives, level, level timer and banner frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      level   <= '0;
      lives   <= LIVES_INIT;
      respawn <= 1'b0;
      timer   <= '0;
      banner  <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      respawn <= 1'b0;
      case (st)
        IDLE: begin
          level <= level_sel;
          if (start_rise) begin
            st      <= PLAY;
            lives   <= LIVES_INIT;
            timer   <= TMR_LOAD;
            respawn <= 1'b1;
          end
        end
        PLAY: begin
          if (hit || timer_expire) begin
            st     <= DYING;
            lives  <= lives - LIVES_W'(1);
            banner <= '0;
          end else if (goal) begin
            st     <= WIN;
            banner <= '0;
          end else if (update && timer != '0) begin
            timer <= timer - TMR_W'(1);
          end
        end
        DYING: begin
          if (update) begin
            if (banner == BAN_LAST) begin
              if (lives == '0) begin
                st <= GAME_OVER;
              end else begin
                st      <= PLAY;
                timer   <= TMR_LOAD;
                respawn <= 1'b1;
              end
            end else begin
              banner <= banner + BAN_W'(1);
            end
          end
        end
        WIN: begin
          // Banner runs first; once it has saturated, only a fresh start leaves.
          if (banner != BAN_DONE) begin
            if (update) begin
              if (banner == BAN_LAST && AUTO_ADVANCE != 0 && level < LVL_MAX) begin
                level   <= level + LVL_W'(1);
                st      <= PLAY;
                timer   <= TMR_LOAD;
                respawn <= 1'b1;
              end else begin
                banner <= banner + BAN_W'(1);
              end
            end
          end else if (start_rise) begin
            st <= IDLE;
          end
        end
        GAME_OVER: begin
          if (start_rise) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  pixel_compositor #(
    .NUM_LEVELS (NUM_LEVELS),
    .LVL_W      (LVL_W),
    .NUM_BLOCKS (NUM_BLOCKS),
    .COLOR_W    (COLOR_W),
    .R_MASK     (R_MASK),
    .G_MASK     (G_MASK)
  ) u_pix (
    .clk         (clk),
    .rst         (rst),
    .state       (st),
    .level       (level),
    .blink       (blink),
    .screen_area (screen_area),
    .player      (player),
    .border      (border),
    .end_zone    (end_zone),
    .blocks      (blocks),
    .banner_text (banner_text),
    .level_text  (level_text),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B)
  );

endmodule

// File: tb/tb_game_state_compositor.sv
// Bench for game_state_compositor: directed game-flow scenario, a behavioural
// game model checked every cycle, and literal spot checks.
module tb_game_state_compositor;

  localparam int NL = 4;
  localparam int LW = 2;
  localparam int NB = 16;
  localparam int CW = 8;
  localparam int LIVES_P = 3;
  localparam int BF = 120;
  localparam int LF = 5;
  localparam logic [NL*NB-1:0] RM = 64'h0000_0000_0001_0000;  // level 1, block 0 red
  localparam logic [NL*NB-1:0] GM = 64'h0000_0000_0002_0000;  // level 1, block 1 green

  localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_WIN = 3, S_GO = 4;

  logic clk, rst, update, start, hit, goal;
  logic [LW-1:0] level_sel;
  logic screen_area, player, border, end_zone, banner_text, level_text;
  logic [NB-1:0] blocks;
  logic respawn;
  logic [LW-1:0] level;
  logic [2:0] lives;
  logic [2:0] state;
  logic [CW-1:0] VGA_R, VGA_G, VGA_B;

  game_state_compositor #(
    .NUM_LEVELS(NL), .LVL_W(LW), .NUM_BLOCKS(NB), .COLOR_W(CW), .LIVES(LIVES_P),
    .BANNER_FRAMES(BF), .LEVEL_FRAMES(LF), .AUTO_ADVANCE(1), .R_MASK(RM), .G_MASK(GM)
  ) dut (
    .clk(clk), .rst(rst), .update(update), .start(start), .level_sel(level_sel),
    .hit(hit), .goal(goal), .screen_area(screen_area), .player(player),
    .border(border), .end_zone(end_zone), .blocks(blocks),
    .banner_text(banner_text), .level_text(level_text), .respawn(respawn),
    .level(level), .lives(lives), .state(state),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;
  int resp_cnt = 0;
  bit pix_manual = 1'b0;
  int pcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural game model ----------------
  int m_state, m_level, m_lives, m_timer, m_banner;
  bit m_resp, start_prev, started;
  logic [2:0] exp_q[$];

  function automatic logic [2:0] exp_colour(input logic sa, pl, bd, ez, bt, lt,
                                            input logic [NB-1:0] bl,
                                            input int st, input int lv, input bit blk);
    logic r, g;
    r = 1'b0;
    g = 1'b0;
    if (!sa) return 3'b000;
    if (st == S_WIN) return {1'b0, !bt, 1'b0};
    if (st == S_GO) return {!bt, 2'b00};
    if (bd && !lt) return 3'b111;
    if (pl) return (st == S_DYING && blk) ? 3'b000 : 3'b100;
    if (ez) return 3'b010;
    for (int i = 0; i < NB; i++) begin
      if (bl[i] && RM[lv*NB + i]) r = 1'b1;
      if (bl[i] && GM[lv*NB + i]) g = 1'b1;
    end
    return {r, g, |bl};
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(3'b000);
      m_state = S_IDLE; m_level = 0; m_lives = LIVES_P;
      m_timer = 0; m_banner = 0; m_resp = 0; start_prev = 0;
    end else begin
      exp_q.push_back(exp_colour(screen_area, player, border, end_zone, banner_text,
                                 level_text, blocks, m_state, m_level,
                                 m_state == S_DYING && ((m_banner >> 3) & 1) == 1));
      m_resp = 0;
      case (m_state)
        S_IDLE: begin
          m_level = int'(level_sel);
          if (start && !start_prev) begin
            m_state = S_PLAY; m_lives = LIVES_P; m_timer = LF; m_resp = 1;
          end
        end
        S_PLAY: begin
          if (hit || (update && LF != 0 && m_timer == 1)) begin
            m_state = S_DYING; m_lives = m_lives - 1; m_banner = 0;
          end else if (goal) begin
            m_state = S_WIN; m_banner = 0;
          end else if (update && m_timer > 0) m_timer = m_timer - 1;
        end
        S_DYING: if (update) begin
          m_banner = m_banner + 1;
          if (m_banner == BF) begin
            if (m_lives == 0) m_state = S_GO;
            else begin m_state = S_PLAY; m_timer = LF; m_resp = 1; end
          end
        end
        S_WIN: begin
          if (m_banner < BF) begin
            if (update) begin
              m_banner = m_banner + 1;
              if (m_banner == BF && m_level < NL - 1) begin
                m_level = m_level + 1; m_state = S_PLAY; m_timer = LF; m_resp = 1;
              end
            end
          end else if (start && !start_prev) m_state = S_IDLE;
        end
        default: if (start && !start_prev) m_state = S_IDLE;
      endcase
      start_prev = start;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [2:0] e;
  always @(negedge clk) begin
    if (started) begin
      chk("state", 32'(state), 32'(m_state));
      chk("level", 32'(level), 32'(m_level));
      chk("lives", 32'(lives), 32'(m_lives));
      chk("respawn", 32'(respawn), 32'(m_resp));
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        chk("vga_r", 32'(VGA_R), 32'({CW{e[2]}}));
        chk("vga_g", 32'(VGA_G), 32'({CW{e[1]}}));
        chk("vga_b", 32'(VGA_B), 32'({CW{e[0]}}));
      end
      if (respawn === 1'b1) resp_cnt++;
    end
  end

  // ---------------- background pixel pattern ----------------
  always @(negedge clk) begin
    if (!pix_manual) begin
      pcnt++;
      screen_area = (pcnt % 7) != 0;
      player      = (pcnt % 4) == 1;
      border      = (pcnt % 5) == 0;
      level_text  = (pcnt % 10) == 0;
      end_zone    = (pcnt % 3) == 0;
      blocks      = NB'(pcnt * 37) & NB'((pcnt % 2 == 0) ? 16'hFFFF : 16'h0303);
      banner_text = (pcnt % 8) >= 4;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      update = 1'b1; step();
      update = 1'b0; step();
    end
  endtask

  task automatic press_start();
    start = 1'b1; step(); step();
    start = 1'b0; step();
  endtask

  task automatic pulse_hit();
    hit = 1'b1; step(); hit = 1'b0; step();
  endtask

  task automatic pulse_goal();
    goal = 1'b1; step(); goal = 1'b0; step();
  endtask

  task automatic set_pix(input logic sa, pl, bd, ez, input logic [NB-1:0] bl,
                         input logic bt, lt);
    pix_manual = 1'b1;
    screen_area = sa; player = pl; border = bd; end_zone = ez;
    blocks = bl; banner_text = bt; level_text = lt;
  endtask

  task automatic chk_rgb(input string name, input logic [CW-1:0] r, g, b);
    chk({name, "_r"}, 32'(VGA_R), 32'(r));
    chk({name, "_g"}, 32'(VGA_G), 32'(g));
    chk({name, "_b"}, 32'(VGA_B), 32'(b));
  endtask

  // ---------------- directed scenario ----------------
  initial begin
    rst = 1'b1; update = 0; start = 0; hit = 0; goal = 0; level_sel = '0;
    screen_area = 0; player = 0; border = 0; end_zone = 0; blocks = '0;
    banner_text = 0; level_text = 0;
    steps(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_respawn", 32'(respawn), 32'd0);
    chk_rgb("rst_vga", 8'h00, 8'h00, 8'h00);
    rst = 1'b0;

    // Start at level 2; start held two cycles gives a single respawn.
    level_sel = 2'd2; step();
    chk("idle_level_follows", 32'(level), 32'd2);
    resp_cnt = 0;
    press_start();
    chk("start_state", 32'(state), 32'd1);
    chk("start_level", 32'(level), 32'd2);
    chk("start_lives", 32'(lives), 32'd3);
    chk("start_respawn_cnt", 32'(resp_cnt), 32'd1);
    level_sel = 2'd0; steps(3);
    chk("play_ignores_sel", 32'(level), 32'd2);

    // First death, boundary at 119/120 banner frames, goal ignored while dying.
    pulse_hit();
    chk("hit1_state", 32'(state), 32'd2);
    chk("hit1_lives", 32'(lives), 32'd2);
    pulse_goal();
    chk("dying_ignores_goal", 32'(state), 32'd2);
    frames(BF - 1);
    chk("banner_119", 32'(state), 32'd2);
    resp_cnt = 0;
    frames(1);
    chk("banner_120", 32'(state), 32'd1);
    chk("respawn_after_death", 32'(resp_cnt), 32'd1);

    pulse_hit(); frames(BF);
    chk("hit2_state", 32'(state), 32'd1);
    chk("hit2_lives", 32'(lives), 32'd1);
    pulse_hit();
    chk("hit3_lives", 32'(lives), 32'd0);
    frames(BF);
    chk("game_over", 32'(state), 32'd4);

    // Game-over field: red with banner holes, black off screen.
    set_pix(1, 0, 0, 0, '0, 0, 0); steps(2);
    chk_rgb("go_field", 8'hFF, 8'h00, 8'h00);
    set_pix(1, 0, 0, 0, '0, 1, 0); steps(2);
    chk_rgb("go_banner", 8'h00, 8'h00, 8'h00);
    set_pix(0, 0, 0, 0, '0, 0, 0); steps(2);
    chk_rgb("go_offscreen", 8'h00, 8'h00, 8'h00);
    pix_manual = 1'b0;
    pulse_hit();
    chk("go_ignores_hit", 32'(state), 32'd4);

    // Held start leaves game over once and must not retrigger play.
    start = 1'b1; step();
    chk("go_to_idle", 32'(state), 32'd0);
    level_sel = 2'd3; steps(4);
    chk("held_start_stays_idle", 32'(state), 32'd0);
    chk("idle_sel3", 32'(level), 32'd3);
    start = 1'b0; step();
    press_start();
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_lives", 32'(lives), 32'd3);

    // Win on the last level: no advance, start returns to idle.
    pulse_goal();
    chk("win_state", 32'(state), 32'd3);
    set_pix(1, 1, 1, 0, '0, 0, 0); steps(2);
    chk_rgb("win_field", 8'h00, 8'hFF, 8'h00);
    pix_manual = 1'b0;
    frames(BF);
    chk("win_last_holds", 32'(state), 32'd3);
    chk("win_last_level", 32'(level), 32'd3);
    press_start();
    chk("win_to_idle", 32'(state), 32'd0);

    // Win on level 0 advances to level 1; then the 5-frame timer.
    level_sel = 2'd0; step();
    press_start();
    pulse_goal();
    frames(BF - 1);
    chk("win_119", 32'(state), 32'd3);
    resp_cnt = 0;
    frames(1);
    chk("advance_state", 32'(state), 32'd1);
    chk("advance_level", 32'(level), 32'd1);
    chk("advance_respawn", 32'(resp_cnt), 32'd1);
    frames(LF - 1);
    chk("timer_4", 32'(state), 32'd1);
    frames(1);
    chk("timer_expired", 32'(state), 32'd2);
    chk("timer_lives", 32'(lives), 32'd2);
    frames(BF);
    hit = 1'b1; goal = 1'b1; step(); hit = 1'b0; goal = 1'b0; step();
    chk("hit_beats_goal", 32'(state), 32'd2);
    chk("hit_goal_lives", 32'(lives), 32'd1);
    frames(BF);
    chk("back_to_play", 32'(state), 32'd1);

    // Pixel priority on level 1, with two-cycle latency.
    set_pix(1, 1, 1, 0, '0, 0, 0); steps(2);
    chk_rgb("border_player", 8'hFF, 8'hFF, 8'hFF);
    set_pix(1, 1, 0, 0, 16'h0001, 0, 0); steps(2);
    chk_rgb("player_block0", 8'hFF, 8'h00, 8'h00);
    set_pix(1, 0, 0, 0, 16'h0001, 0, 0); steps(2);
    chk_rgb("block0", 8'hFF, 8'h00, 8'hFF);
    set_pix(1, 0, 0, 0, 16'h0002, 0, 0); steps(2);
    chk_rgb("block1", 8'h00, 8'hFF, 8'hFF);
    set_pix(1, 1, 1, 0, '0, 0, 1); steps(2);
    chk_rgb("text_border_player", 8'hFF, 8'h00, 8'h00);
    set_pix(1, 0, 0, 1, 16'h0001, 0, 0); steps(2);
    chk_rgb("endzone", 8'h00, 8'hFF, 8'h00);
    set_pix(0, 0, 0, 0, '0, 0, 0); step();
    chk_rgb("latency_1clk", 8'h00, 8'hFF, 8'h00);
    step();
    chk_rgb("latency_2clk", 8'h00, 8'h00, 8'h00);
    pix_manual = 1'b0;
    steps(4);

    // Reset in the middle of play.
    rst = 1'b1; step();
    chk("midrst_state", 32'(state), 32'd0);
    chk_rgb("midrst_vga", 8'h00, 8'h00, 8'h00);
    rst = 1'b0; steps(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
